// File: rtl/control_multiciclo_if.sv
// Control bus between the multicycle MIPS32 controller and its datapath.
// The controller is the master: it consumes opcode/zero and drives every select.
interface control_multiciclo_if #(
    parameter int SIZE_OP  = 6,
    parameter int SIZE_CNT = 32
);
    logic [SIZE_OP-1:0]  opcode;
    logic                zero;
    logic                pc_en;
    logic                ir_write;
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;
    logic                ext_unsigned;
    logic                illegal;
    logic [SIZE_CNT-1:0] instr_retired;
    logic [3:0]          state;

    modport master (
        input  opcode, zero,
        output pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               ext_unsigned, illegal, instr_retired, state
    );

    modport slave (
        output opcode, zero,
        input  pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               ext_unsigned, illegal, instr_retired, state
    );
endinterface

// File: rtl/control_multiciclo.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the ArqMIPS32 datapath selects, including the immediate extension mode.
module control_multiciclo #(
    parameter int SIZE_OP  = 6,
    parameter int SIZE_CNT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_multiciclo_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

    localparam logic [SIZE_OP-1:0] OP_RTYPE = SIZE_OP'(6'h00);
    localparam logic [SIZE_OP-1:0] OP_J     = SIZE_OP'(6'h02);
    localparam logic [SIZE_OP-1:0] OP_BEQ   = SIZE_OP'(6'h04);
    localparam logic [SIZE_OP-1:0] OP_BNE   = SIZE_OP'(6'h05);
    localparam logic [SIZE_OP-1:0] OP_ADDI  = SIZE_OP'(6'h08);
    localparam logic [SIZE_OP-1:0] OP_SLTI  = SIZE_OP'(6'h0A);
    localparam logic [SIZE_OP-1:0] OP_ANDI  = SIZE_OP'(6'h0C);
    localparam logic [SIZE_OP-1:0] OP_ORI   = SIZE_OP'(6'h0D);
    localparam logic [SIZE_OP-1:0] OP_XORI  = SIZE_OP'(6'h0E);
    localparam logic [SIZE_OP-1:0] OP_LUI   = SIZE_OP'(6'h0F);
    localparam logic [SIZE_OP-1:0] OP_LW    = SIZE_OP'(6'h23);
    localparam logic [SIZE_OP-1:0] OP_SW    = SIZE_OP'(6'h2B);

    // Moore select pattern of each state; anything a state does not name stays 0.
    function automatic ctl_t decodeCtl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.pc_en     = 1'b1;
                c.ir_write  = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE:   c.alu_src_b = 2'b11;
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
            end
            JUMP: begin
                c.pc_en     = 1'b1;
                c.pc_source = 2'b10;
            end
            I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            I_WB:    c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t              state_q, state_d;
    ctl_t                ctl_q, ctlOut;
    logic                illegal_q;
    logic [SIZE_CNT-1:0] retired_q;
    logic                retire;
    logic                branchTaken;
    logic                isLogicalImm;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (bus.opcode == OP_RTYPE)
                    state_d = R_EXEC;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)
                    state_d = MEM_ADDR;
                else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE)
                    state_d = BRANCH;
                else if (bus.opcode == OP_J)
                    state_d = JUMP;
                else if (bus.opcode == OP_ADDI || bus.opcode == OP_SLTI || isLogicalImm)
                    state_d = I_EXEC;
                else
                    state_d = TRAP;
            end
            MEM_ADDR: state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = MEM_WB;
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB: state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    assign retire = (state_d == FETCH) &&
                    (state_q == MEM_WB || state_q == MEM_WR || state_q == R_WB ||
                     state_q == BRANCH || state_q == JUMP   || state_q == I_WB);

    // Selects are registered from the next state, so the reset value is the FETCH pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ctl_q     <= decodeCtl(FETCH);
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= decodeCtl(state_d);
            if (state_d == TRAP)
                illegal_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign isLogicalImm = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI) ||
                          (bus.opcode == OP_XORI) || (bus.opcode == OP_LUI);
    assign branchTaken  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;

    // Reset gates every select combinationally so nothing reaches the datapath mid-reset.
    assign ctlOut = rst_n ? ctl_q : '0;

    assign bus.pc_en         = rst_n & (ctl_q.pc_en | ((state_q == BRANCH) & branchTaken));
    assign bus.ir_write      = ctlOut.ir_write;
    assign bus.mem_read      = ctlOut.mem_read;
    assign bus.mem_write     = ctlOut.mem_write;
    assign bus.iord          = ctlOut.iord;
    assign bus.reg_write     = ctlOut.reg_write;
    assign bus.reg_dst       = ctlOut.reg_dst;
    assign bus.mem_to_reg    = ctlOut.mem_to_reg;
    assign bus.alu_src_a     = ctlOut.alu_src_a;
    assign bus.alu_src_b     = ctlOut.alu_src_b;
    assign bus.alu_op        = ctlOut.alu_op;
    assign bus.pc_source     = ctlOut.pc_source;
    assign bus.ext_unsigned  = (state_q != FETCH) && isLogicalImm;
    assign bus.illegal       = illegal_q;
    assign bus.instr_retired = retired_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-cycle vector table plus TRAP,
// mid-instruction reset and counter-wrap sequences (4-bit counter instance).
module tb_control_multiciclo;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [13:0] ctl;
        logic        ext;
        logic        pcEn;
        int          ret;
    } vec_t;

    // Packed as {ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
    //            alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
    localparam logic [13:0] C_NONE   = 14'b0;
    localparam logic [13:0] C_FETCH  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
    localparam logic [13:0] C_DECODE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
    localparam logic [13:0] C_MADDR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
    localparam logic [13:0] C_MRD    = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_MWR    = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_REXEC  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
    localparam logic [13:0] C_RWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_BRANCH = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
    localparam logic [13:0] C_JUMP   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
    localparam logic [13:0] C_IEXEC  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00};
    localparam logic [13:0] C_IWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};

    logic clk;
    logic rst_n;
    int   testsRun;
    int   failures;
    vec_t vecs[$];

    control_multiciclo_if #(.SIZE_OP(6), .SIZE_CNT(4)) bus ();

    control_multiciclo #(.SIZE_OP(6), .SIZE_CNT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [13:0] ctlNow();
        return {bus.ir_write, bus.mem_read, bus.mem_write, bus.iord, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source};
    endfunction

    function automatic void addVec(input logic [5:0] op, input logic zero, input logic [3:0] st,
                                   input logic [13:0] ctl, input logic ext, input logic pcEn,
                                   input int ret);
        vec_t v;
        v.op = op; v.zero = zero; v.st = st; v.ctl = ctl;
        v.ext = ext; v.pcEn = pcEn; v.ret = ret;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic zero);
        bus.opcode = op;
        bus.zero   = zero;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] st, input logic [13:0] ctl,
                               input logic ext, input logic pcEn, input logic ill, input int ret);
        checkVal({tag, " state"}, 32'(bus.state), 32'(st));
        checkVal({tag, " ctl"}, 32'(ctlNow()), 32'(ctl));
        checkVal({tag, " ext_unsigned"}, 32'(bus.ext_unsigned), 32'(ext));
        checkVal({tag, " pc_en"}, 32'(bus.pc_en), 32'(pcEn));
        checkVal({tag, " illegal"}, 32'(bus.illegal), 32'(ill));
        checkVal({tag, " instr_retired"}, 32'(bus.instr_retired), ret);
    endtask

    initial begin
        logic found;
        testsRun = 0;
        failures = 0;

        // R-type, LW, ORI, ADDI, BEQ/BNE both ways, SW, J: one row per cycle.
        addVec(6'h00, 0, 4'd0, C_FETCH, 0, 1, 0);  addVec(6'h00, 0, 4'd1, C_DECODE, 0, 0, 0);
        addVec(6'h00, 0, 4'd6, C_REXEC, 0, 0, 0);  addVec(6'h00, 0, 4'd7, C_RWB, 0, 0, 0);
        addVec(6'h23, 0, 4'd0, C_FETCH, 0, 1, 1);  addVec(6'h23, 0, 4'd1, C_DECODE, 0, 0, 1);
        addVec(6'h23, 0, 4'd2, C_MADDR, 0, 0, 1);  addVec(6'h23, 0, 4'd3, C_MRD, 0, 0, 1);
        addVec(6'h23, 0, 4'd4, C_MWB, 0, 0, 1);
        addVec(6'h0D, 0, 4'd0, C_FETCH, 0, 1, 2);  addVec(6'h0D, 0, 4'd1, C_DECODE, 1, 0, 2);
        addVec(6'h0D, 0, 4'd10, C_IEXEC, 1, 0, 2); addVec(6'h0D, 0, 4'd11, C_IWB, 1, 0, 2);
        addVec(6'h08, 0, 4'd0, C_FETCH, 0, 1, 3);  addVec(6'h08, 0, 4'd1, C_DECODE, 0, 0, 3);
        addVec(6'h08, 0, 4'd10, C_IEXEC, 0, 0, 3); addVec(6'h08, 0, 4'd11, C_IWB, 0, 0, 3);
        addVec(6'h04, 1, 4'd0, C_FETCH, 0, 1, 4);  addVec(6'h04, 1, 4'd1, C_DECODE, 0, 0, 4);
        addVec(6'h04, 1, 4'd8, C_BRANCH, 0, 1, 4);
        addVec(6'h04, 0, 4'd0, C_FETCH, 0, 1, 5);  addVec(6'h04, 0, 4'd1, C_DECODE, 0, 0, 5);
        addVec(6'h04, 0, 4'd8, C_BRANCH, 0, 0, 5);
        addVec(6'h05, 1, 4'd0, C_FETCH, 0, 1, 6);  addVec(6'h05, 1, 4'd1, C_DECODE, 0, 0, 6);
        addVec(6'h05, 1, 4'd8, C_BRANCH, 0, 0, 6);
        addVec(6'h05, 0, 4'd0, C_FETCH, 0, 1, 7);  addVec(6'h05, 0, 4'd1, C_DECODE, 0, 0, 7);
        addVec(6'h05, 0, 4'd8, C_BRANCH, 0, 1, 7);
        addVec(6'h2B, 0, 4'd0, C_FETCH, 0, 1, 8);  addVec(6'h2B, 0, 4'd1, C_DECODE, 0, 0, 8);
        addVec(6'h2B, 0, 4'd2, C_MADDR, 0, 0, 8);  addVec(6'h2B, 0, 4'd5, C_MWR, 0, 0, 8);
        addVec(6'h02, 0, 4'd0, C_FETCH, 0, 1, 9);  addVec(6'h02, 0, 4'd1, C_DECODE, 0, 0, 9);
        addVec(6'h02, 0, 4'd9, C_JUMP, 0, 1, 9);

        // Reset: FETCH state but every enable and select held low.
        applyStimulus(6'h0D, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 checkOutput("reset", 4'd0, C_NONE, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].zero);
            #1 checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl,
                           vecs[i].ext, vecs[i].pcEn, 0, vecs[i].ret);
            @(negedge clk);
        end

        // Unsupported opcode: TRAP, sticky illegal, frozen counter.
        applyStimulus(6'h3F, 1'b0);
        #1 checkOutput("trap fetch", 4'd0, C_FETCH, 0, 1, 0, 10);
        @(negedge clk);
        #1 checkOutput("trap decode", 4'd1, C_DECODE, 0, 0, 0, 10);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1 checkOutput($sformatf("trap c%0d", k), 4'd12, C_NONE, 0, 0, 1, 10);
        end
        rst_n = 1'b0;
        #1 checkOutput("trap reset", 4'd0, C_NONE, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset dropped between edges while a store is writing.
        applyStimulus(6'h2B, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            #1 if (bus.state == 4'd5) found = 1'b1;
        end
        checkVal("reach MEM_WR", 32'(found), 32'd1);
        checkVal("mem_write before reset", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1 checkOutput("sw reset", 4'd0, C_NONE, 0, 0, 0, 0);
        @(posedge clk);
        #1 checkOutput("sw reset held", 4'd0, C_NONE, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fifteen jumps bring the 4-bit counter to all ones; one more wraps it.
        applyStimulus(6'h02, 1'b0);
        repeat (45) @(negedge clk);
        #1 checkOutput("count ones", 4'd0, C_FETCH, 0, 1, 0, 15);
        repeat (3) @(negedge clk);
        #1 checkOutput("count wrap", 4'd0, C_FETCH, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
